// File: rtl/wb_retire_unit_if.sv
// MEM/WB payload in, register-file write port and retire status out.
interface wb_retire_unit_if #(
  parameter int WORD_SIZE = 16,
  parameter int RF_ADDR_W = 2,
  parameter int CNT_W     = 16
);
  logic                 valid_in;
  logic                 stall;
  logic [15:0]          instruction;
  logic [WORD_SIZE-1:0] m_data;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 rf_write;
  logic [RF_ADDR_W-1:0] addr3;
  logic [WORD_SIZE-1:0] data3;
  logic                 fwd_valid;
  logic [WORD_SIZE-1:0] output_port;
  logic                 output_strobe;
  logic [CNT_W-1:0]     num_inst;
  logic                 is_halted;

  modport master (
    output valid_in, stall, instruction, m_data, alu_out,
    input  rf_write, addr3, data3, fwd_valid, output_port, output_strobe,
           num_inst, is_halted
  );

  modport slave (
    input  valid_in, stall, instruction, m_data, alu_out,
    output rf_write, addr3, data3, fwd_valid, output_port, output_strobe,
           num_inst, is_halted
  );
endinterface

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: registers MEM/WB payload, drives the RF write port,
// counts retired instructions, latches WWD output and a sticky halt.
module wb_retire_unit #(
  parameter int WORD_SIZE = 16,
  parameter int RF_ADDR_W = 2,
  parameter int LINK_REG  = 2,
  parameter int CNT_W     = 16
) (
  input logic          clk,
  input logic          reset_n,
  wb_retire_unit_if.slave wb
);
  localparam logic [3:0] OP_ADI = 4'd4,  OP_ORI = 4'd5, OP_LHI = 4'd6,
                         OP_LWD = 4'd7,  OP_JAL = 4'd10, OP_RRR = 4'd15;
  localparam logic [5:0] F_JPR = 6'd25, F_JRL = 6'd26, F_WWD = 6'd28, F_HLT = 6'd29;
  localparam int XW = (RF_ADDR_W > 2) ? RF_ADDR_W : 2;
  localparam logic [RF_ADDR_W-1:0] LINK_A = RF_ADDR_W'(LINK_REG);

  typedef struct packed {
    logic                 valid;
    logic [15:0]          instr;
    logic [WORD_SIZE-1:0] m_data;
    logic [WORD_SIZE-1:0] alu_out;
  } wb_req_t;

  wb_req_t              q;
  logic [CNT_W-1:0]     num_q;
  logic [WORD_SIZE-1:0] oport_q;
  logic                 strobe_q, halted_q;

  logic                 dec_wr, is_wwd, is_hlt, retire, capture;
  logic [RF_ADDR_W-1:0] dec_addr, rt_a, rd_a;
  logic [WORD_SIZE-1:0] dec_data;
  logic [XW-1:0]        rt_x, rd_x;

  // rt/rd fields are 2 bits; widen or narrow to the RF address width
  assign rt_x = XW'(q.instr[9:8]);
  assign rd_x = XW'(q.instr[7:6]);
  assign rt_a = rt_x[RF_ADDR_W-1:0];
  assign rd_a = rd_x[RF_ADDR_W-1:0];

  always_comb begin
    dec_wr   = 1'b0;
    dec_addr = '0;
    dec_data = '0;
    is_wwd   = 1'b0;
    is_hlt   = 1'b0;
    case (q.instr[15:12])
      OP_ADI, OP_ORI, OP_LHI: begin dec_wr = 1'b1; dec_addr = rt_a;   dec_data = q.alu_out; end
      OP_LWD:                 begin dec_wr = 1'b1; dec_addr = rt_a;   dec_data = q.m_data;  end
      OP_JAL:                 begin dec_wr = 1'b1; dec_addr = LINK_A; dec_data = q.alu_out; end
      OP_RRR: begin
        case (q.instr[5:0])
          F_JRL:   begin dec_wr = 1'b1; dec_addr = LINK_A; dec_data = q.alu_out; end
          F_WWD:   is_wwd = 1'b1;
          F_JPR:   ;
          F_HLT:   is_hlt = 1'b1;
          default: begin dec_wr = 1'b1; dec_addr = rd_a; dec_data = q.alu_out; end
        endcase
      end
      default: ;
    endcase
  end

  // A halting retire also blocks the capture on the same edge
  assign retire  = q.valid & ~wb.stall & ~halted_q;
  assign capture = ~wb.stall & ~halted_q & ~(retire & is_hlt);

  always_comb begin
    wb.rf_write      = retire & dec_wr;
    wb.addr3         = wb.rf_write ? dec_addr : '0;
    wb.data3         = wb.rf_write ? dec_data : '0;
    wb.fwd_valid     = wb.rf_write;
    wb.output_port   = oport_q;
    wb.output_strobe = strobe_q;
    wb.num_inst      = num_q;
    wb.is_halted     = halted_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q        <= '0;
      num_q    <= '0;
      oport_q  <= '0;
      strobe_q <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      strobe_q <= retire & is_wwd;
      if (retire) begin
        num_q <= num_q + CNT_W'(1);
        if (is_wwd) oport_q  <= q.alu_out;
        if (is_hlt) halted_q <= 1'b1;
      end
      if (capture) q <= '{valid: wb.valid_in, instr: wb.instruction,
                          m_data: wb.m_data, alu_out: wb.alu_out};
    end
  end
endmodule
